// File: rtl/issue_scoreboard_pkg.sv
// Shared ISA constants and scoreboard types for the WISC decode-stage issue controller.
package issue_scoreboard_pkg;

    localparam logic [15:0] NOP_INSTR       = 16'h0800;
    localparam int          NUM_GPR         = 8;
    localparam int          GPR_W           = 3;
    localparam int          WB_DIST_DEFAULT = 3;
    localparam int          CNT_W_DEFAULT   = 3;

    typedef logic [GPR_W-1:0]   gpr_idx_t;
    typedef logic [NUM_GPR-1:0] gpr_vec_t;

    // A source operand is blocked only if the instruction actually reads it.
    function automatic logic reads_busy(input logic used, input gpr_vec_t busy, input gpr_idx_t idx);
        return used & busy[idx];
    endfunction

endpackage

// File: rtl/issue_scoreboard_sb_entry.sv
// One scoreboard entry: cycles remaining until a pending GPR write becomes readable.
module sb_entry
    import issue_scoreboard_pkg::*;
#(
    parameter int WB_DIST = WB_DIST_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             hold,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WB_DIST);

    // A reload wins over the decrement so a WAW rewrite restarts the full distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (hold) begin
            count <= count;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue controller: per-GPR countdown scoreboard deciding issue, bubble or squash.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int WB_DIST = WB_DIST_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [15:0] id_instr,
    input  logic        id_rs_used,
    input  logic [2:0]  id_rs,
    input  logic        id_rt_used,
    input  logic [2:0]  id_rt,
    input  logic        id_wr_en,
    input  logic [2:0]  id_wr_reg,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic [15:0] ex_instr,
    output logic [7:0]  busy_vec,
    output logic [15:0] stall_cycles
);

    gpr_vec_t         busy;
    logic [CNT_W-1:0] count [NUM_GPR];
    logic             hz;

    // Handshake: issue is the valid toward ID/EX (it takes ex_instr every edge, NOP when
    // issue=0); stall is not-ready back toward IF/ID; mem_stall freezes both sides at once.
    assign hz       = reads_busy(id_rs_used, busy, id_rs) | reads_busy(id_rt_used, busy, id_rt);
    assign stall    = id_valid &  hz & ~flush & ~mem_stall;
    assign issue    = id_valid & ~hz & ~flush & ~mem_stall;
    assign ex_instr = issue ? id_instr : NOP_INSTR;

    for (genvar g = 0; g < NUM_GPR; g++) begin : g_entry
        sb_entry #(
            .WB_DIST(WB_DIST),
            .CNT_W  (CNT_W)
        ) u_entry (
            .clk  (clk),
            .rst  (rst),
            .load (issue & id_wr_en & (id_wr_reg == GPR_W'(g))),
            .hold (mem_stall),
            .busy (busy[g]),
            .count(count[g])
        );
        assign busy_vec[g] = (count[g] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard against a ready-time reference model.
module tb_issue_scoreboard;

    localparam int WB     = 3;
    localparam int WB_SAT = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_used, id_rt_used, id_wr_en, mem_stall, flush;
    logic [15:0] id_instr;
    logic [2:0]  id_rs, id_rt, id_wr_reg;
    logic        stall, issue, sat_stall, sat_issue;
    logic [15:0] ex_instr, stall_cycles, sat_ex_instr, sat_stall_cycles;
    logic [7:0]  busy_vec, sat_busy_vec;

    int errors = 0;
    int checks = 0;

    // Reference model: each GPR is readable from an absolute "active cycle" onward;
    // frozen cycles do not advance time.
    int now;
    int ready_at [8];
    int m_sc;
    logic        e_stall, e_issue;
    logic [15:0] e_ex;
    logic [7:0]  e_busy;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_used(id_rs_used), .id_rs(id_rs), .id_rt_used(id_rt_used), .id_rt(id_rt),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .mem_stall(mem_stall), .flush(flush),
        .stall(stall), .issue(issue), .ex_instr(ex_instr), .busy_vec(busy_vec),
        .stall_cycles(stall_cycles)
    );

    issue_scoreboard #(.WB_DIST(WB_SAT)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_used(id_rs_used), .id_rs(id_rs), .id_rt_used(id_rt_used), .id_rt(id_rt),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .mem_stall(mem_stall), .flush(flush),
        .stall(sat_stall), .issue(sat_issue), .ex_instr(sat_ex_instr), .busy_vec(sat_busy_vec),
        .stall_cycles(sat_stall_cycles)
    );

    task automatic model_reset();
        now  = 0;
        m_sc = 0;
        for (int i = 0; i < 8; i++) ready_at[i] = 0;
    endtask

    task automatic model_eval();
        logic hz;
        hz      = (id_rs_used && ready_at[id_rs] > now) || (id_rt_used && ready_at[id_rt] > now);
        e_stall = id_valid && hz && !flush && !mem_stall;
        e_issue = id_valid && !hz && !flush && !mem_stall;
        e_ex    = e_issue ? id_instr : 16'h0800;
        for (int i = 0; i < 8; i++) e_busy[i] = (ready_at[i] > now);
    endtask

    // Advance the model across the coming edge, then move to just after it.
    task automatic tick();
        model_eval();
        if (!mem_stall) begin
            if (e_issue && id_wr_en) ready_at[id_wr_reg] = now + 1 + WB;
            if (e_stall && m_sc < 65535) m_sc++;
            now++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic rsu, input logic [2:0] rs,
                         input logic rtu, input logic [2:0] rt, input logic we, input logic [2:0] wr,
                         input logic ms, input logic fl);
        id_valid = v;   id_instr = instr; id_rs_used = rsu; id_rs = rs;
        id_rt_used = rtu; id_rt = rt; id_wr_en = we; id_wr_reg = wr;
        mem_stall = ms; flush = fl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        checks += 5;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue got %b want 0", issue); end
        if (ex_instr !== 16'h0800) begin errors++; $display("FAIL reset_ex got %h want 0800", ex_instr); end
        if (busy_vec !== 8'h00) begin errors++; $display("FAIL reset_busy got %h want 00", busy_vec); end
        if (stall_cycles !== 16'h0) begin errors++; $display("FAIL reset_sc got %0d want 0", stall_cycles); end
        tick();
    endtask

    task automatic test_single_write();
        drive(1, 16'hC8E3, 1, 1, 1, 2, 1, 3, 0, 0);
        @(negedge clk);
        checks += 2;
        if (issue !== 1'b1) begin errors++; $display("FAIL wr3_issue got %b want 1", issue); end
        if (ex_instr !== 16'hC8E3) begin errors++; $display("FAIL wr3_ex got %h want c8e3", ex_instr); end
        tick();
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= WB; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (busy_vec !== e_busy) begin errors++; $display("FAIL wr3_busy step %0d got %h want %h", i, busy_vec, e_busy); end
            tick();
        end
    endtask

    task automatic test_raw();
        int  sc_before;
        logic done;
        drive(1, 16'hC8E3, 0, 0, 0, 0, 1, 3, 0, 0);
        tick();
        sc_before = m_sc;
        exp_q.delete();
        for (int i = 0; i < WB; i++) exp_q.push_back(16'h0800);
        exp_q.push_back(16'h4B60);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            logic [15:0] want;
            drive(1, 16'h4B60, 1, 3, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            want = exp_q.pop_front();
            checks += 2;
            if (ex_instr !== want) begin errors++; $display("FAIL raw_ex cycle %0d got %h want %h", c, ex_instr, want); end
            if (stall !== (exp_q.size() != 0)) begin errors++; $display("FAIL raw_stall cycle %0d got %b want %b", c, stall, exp_q.size() != 0); end
            if (exp_q.size() == 0) done = 1'b1;
            tick();
        end
        checks += 2;
        if (!done) begin errors++; $display("FAIL raw_timeout got no issue want issue within 20 cycles"); end
        if (stall_cycles !== 16'(sc_before + WB)) begin errors++; $display("FAIL raw_sc got %0d want %0d", stall_cycles, sc_before + WB); end
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (WB) tick();
    endtask

    task automatic test_mem_stall();
        int   sc_before, bubbles;
        logic done;
        drive(1, 16'hC904, 0, 0, 0, 0, 1, 4, 0, 0);
        tick();
        sc_before = m_sc;
        bubbles   = 0;
        done      = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            logic ms;
            ms = (c >= 1 && c < 6);
            drive(1, 16'h4C00, 1, 4, 0, 0, 0, 0, ms, 0);
            @(negedge clk);
            model_eval();
            if (ms) begin
                checks += 3;
                if (stall !== 1'b0) begin errors++; $display("FAIL frz_stall cycle %0d got %b want 0", c, stall); end
                if (busy_vec !== e_busy) begin errors++; $display("FAIL frz_busy cycle %0d got %h want %h", c, busy_vec, e_busy); end
                if (stall_cycles !== 16'(m_sc)) begin errors++; $display("FAIL frz_sc cycle %0d got %0d want %0d", c, stall_cycles, m_sc); end
            end
            if (stall) bubbles++;
            if (issue) done = 1'b1;
            tick();
        end
        checks += 3;
        if (!done) begin errors++; $display("FAIL frz_timeout got no issue want issue within 30 cycles"); end
        if (bubbles != WB) begin errors++; $display("FAIL frz_bubbles got %0d want %0d", bubbles, WB); end
        if (stall_cycles !== 16'(sc_before + WB)) begin errors++; $display("FAIL frz_sc_total got %0d want %0d", stall_cycles, sc_before + WB); end
    endtask

    task automatic test_flush();
        drive(1, 16'hC9A5, 1, 0, 0, 0, 1, 5, 0, 1);
        @(negedge clk);
        checks += 2;
        if (issue !== 1'b0) begin errors++; $display("FAIL flush_issue got %b want 0", issue); end
        if (ex_instr !== 16'h0800) begin errors++; $display("FAIL flush_ex got %h want 0800", ex_instr); end
        tick();
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL flush_busy5 got %b want 0", busy_vec[5]); end
        tick();
    endtask

    task automatic test_waw();
        int   bubbles;
        logic done;
        drive(1, 16'hC842, 0, 0, 0, 0, 1, 2, 0, 0);
        tick();
        drive(1, 16'hC862, 1, 1, 0, 0, 1, 2, 0, 0);
        @(negedge clk);
        checks++;
        if (issue !== 1'b1) begin errors++; $display("FAIL waw_issue got %b want 1", issue); end
        tick();
        bubbles = 0;
        done    = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            drive(1, 16'h4A40, 0, 0, 1, 2, 0, 0, 0, 0);
            @(negedge clk);
            if (stall) bubbles++;
            if (issue) done = 1'b1;
            tick();
        end
        checks += 2;
        if (!done) begin errors++; $display("FAIL waw_timeout got no issue want issue within 20 cycles"); end
        if (bubbles != WB) begin errors++; $display("FAIL waw_bubbles got %0d want %0d", bubbles, WB); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            @(negedge clk);
            model_eval();
            checks += 5;
            if (stall !== e_stall) begin errors++; $display("FAIL rand_stall cycle %0d got %b want %b", c, stall, e_stall); end
            if (issue !== e_issue) begin errors++; $display("FAIL rand_issue cycle %0d got %b want %b", c, issue, e_issue); end
            if (ex_instr !== e_ex) begin errors++; $display("FAIL rand_ex cycle %0d got %h want %h", c, ex_instr, e_ex); end
            if (busy_vec !== e_busy) begin errors++; $display("FAIL rand_busy cycle %0d got %h want %h", c, busy_vec, e_busy); end
            if (stall_cycles !== 16'(m_sc)) begin errors++; $display("FAIL rand_sc cycle %0d got %0d want %0d", c, stall_cycles, m_sc); end
            tick();
        end
    endtask

    // Chain of instructions each reading the previous one's destination keeps
    // the WB_DIST=7 instance stalled 7 of every 8 cycles.
    task automatic test_saturate_and_reset();
        int k;
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        k = 0;
        for (int c = 0; c < 80000 && k < 9400; c++) begin
            drive(1, 16'(k), 1, 3'(k & 1), 0, 0, 1, 3'((k + 1) & 1), 0, 0);
            @(negedge clk);
            if (sat_issue) begin
                k++;
                if (k == 101) begin
                    checks++;
                    if (sat_stall_cycles !== 16'd700) begin errors++; $display("FAIL sat_mid_sc got %0d want 700", sat_stall_cycles); end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (k < 9400) begin errors++; $display("FAIL sat_timeout got %0d issues want 9400", k); end
        drive(1, 16'(k), 1, 3'(k & 1), 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks += 2;
        if (sat_stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %b want 1", sat_stall); end
        if (sat_stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_sc got %h want ffff", sat_stall_cycles); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks += 5;
        if (sat_busy_vec !== 8'h00) begin errors++; $display("FAIL rst_busy got %h want 00", sat_busy_vec); end
        if (sat_stall_cycles !== 16'h0) begin errors++; $display("FAIL rst_sc got %0d want 0", sat_stall_cycles); end
        if (sat_issue !== 1'b1) begin errors++; $display("FAIL rst_issue got %b want 1", sat_issue); end
        if (sat_ex_instr !== 16'(k)) begin errors++; $display("FAIL rst_ex got %h want %h", sat_ex_instr, 16'(k)); end
        if (issue !== 1'b1) begin errors++; $display("FAIL rst_issue_main got %b want 1", issue); end
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_raw();
        test_mem_stall();
        test_flush();
        test_waw();
        test_random();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
